// File: rtl/pc_stack_unit.sv
// Program counter with a circular return-address stack for CALL/RET and a fetch stall.
// Define PC_STACK_ERR_EN to add the sticky overflow/underflow flag (stk_err) and its clear (err_clr).
module pc_stack_unit #(
  parameter int AW    = 16,
  parameter int OW    = 16,
  parameter int DEPTH = 4,
  parameter logic [AW-1:0] RST_VEC = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall,
  input  logic [2:0]               ps_in,
  input  logic [OW-1:0]            ia_in,
  input  logic [AW-1:0]            ra_in,
`ifdef PC_STACK_ERR_EN
  input  logic                     err_clr,
  output logic                     stk_err,
`endif
  output logic [AW-1:0]            pc_out,
  output logic [$clog2(DEPTH):0]   stk_cnt,
  output logic                     stk_empty,
  output logic                     stk_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_INC  = 3'b001,
    OP_BRA  = 3'b010,
    OP_JMP  = 3'b011,
    OP_CALL = 3'b100,
    OP_RET  = 3'b101,
    OP_RSV6 = 3'b110,
    OP_RSV7 = 3'b111
  } op_e;

  logic [AW-1:0] r_pc;
  logic [PW-1:0] r_wp;
  logic [CW-1:0] r_cnt;
  logic          r_empty;
  logic          r_full;
  logic [AW-1:0] r_stack [DEPTH];

  op_e           w_op;
  logic [AW-1:0] w_sext;
  logic [AW-1:0] w_pc_inc;
  logic [AW-1:0] w_top;
  logic          w_push;
  logic          w_pop;
  logic [AW-1:0] w_pc_next;
  logic [CW-1:0] w_cnt_next;
  logic [PW-1:0] w_wp_next;

  generate
    if (OW < AW) begin : g_sext
      assign w_sext = {{(AW-OW){ia_in[OW-1]}}, ia_in};
    end else begin : g_nosext
      assign w_sext = ia_in[AW-1:0];
    end
  endgenerate

  assign w_op     = op_e'(ps_in);
  assign w_pc_inc = r_pc + AW'(1);
  assign w_top    = r_stack[r_wp - PW'(1)];
  assign w_push   = !stall && (w_op == OP_CALL);
  // A RET on an empty stack degrades to INC and must not move the pointer.
  assign w_pop    = !stall && (w_op == OP_RET) && !r_empty;

  always_comb begin
    w_pc_next = r_pc;
    if (!stall) begin
      case (w_op)
        OP_INC:  w_pc_next = w_pc_inc;
        OP_BRA:  w_pc_next = r_pc + w_sext;
        OP_JMP:  w_pc_next = ra_in;
        OP_CALL: w_pc_next = ra_in;
        OP_RET:  w_pc_next = r_empty ? w_pc_inc : w_top;
        default: w_pc_next = r_pc;
      endcase
    end
  end

  always_comb begin
    w_cnt_next = r_cnt;
    w_wp_next  = r_wp;
    if (w_push) begin
      w_wp_next = r_wp + PW'(1);
      if (!r_full) w_cnt_next = r_cnt + CW'(1);
    end else if (w_pop) begin
      w_wp_next  = r_wp - PW'(1);
      w_cnt_next = r_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= RST_VEC;
      r_wp    <= '0;
      r_cnt   <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      r_pc    <= w_pc_next;
      r_wp    <= w_wp_next;
      r_cnt   <= w_cnt_next;
      r_empty <= (w_cnt_next == '0);
      r_full  <= (w_cnt_next == FULL_CNT);
    end
  end

  // Stack contents need no reset; validity is tracked by the counter.
  always_ff @(posedge clk) begin
    if (w_push) r_stack[r_wp] <= w_pc_inc;
  end

`ifdef PC_STACK_ERR_EN
  logic r_err;
  logic w_err_set;

  assign w_err_set = !stall && (((w_op == OP_CALL) && r_full) || ((w_op == OP_RET) && r_empty));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_err <= 1'b0;
    else if (w_err_set) r_err <= 1'b1;
    else if (err_clr)   r_err <= 1'b0;
  end

  assign stk_err = r_err;
`endif

  assign pc_out    = r_pc;
  assign stk_cnt   = r_cnt;
  assign stk_empty = r_empty;
  assign stk_full  = r_full;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Bench for pc_stack_unit: queue-based reference model checked every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_pc_stack_unit;
  localparam int AW = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall = 1'b0;
  logic [2:0]    ps_in = 3'b000;
  logic [15:0]   ia_in = '0;
  logic [15:0]   ra_in = '0;
  logic [15:0]   pc_out;
  logic [2:0]    stk_cnt;
  logic          stk_empty;
  logic          stk_full;
`ifdef PC_STACK_ERR_EN
  logic          err_clr = 1'b0;
  logic          stk_err;
`endif

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  pc_stack_unit #(.AW(16), .OW(16), .DEPTH(4), .RST_VEC(16'h0000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .ps_in     (ps_in),
    .ia_in     (ia_in),
    .ra_in     (ra_in),
`ifdef PC_STACK_ERR_EN
    .err_clr   (err_clr),
    .stk_err   (stk_err),
`endif
    .pc_out    (pc_out),
    .stk_cnt   (stk_cnt),
    .stk_empty (stk_empty),
    .stk_full  (stk_full)
  );

  always #5 clk = ~clk;

  // Reference model: PC as an integer mod 2^16, return stack as a bounded queue.
  logic [15:0] m_pc = 16'h0000;
  logic [15:0] m_stk [$];
  bit          m_err = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 16'h0000;
      m_stk.delete();
      m_err = 1'b0;
    end else begin
      bit set_err;
      set_err = !stall && ((ps_in == 3'd4 && m_stk.size() == DEPTH) ||
                           (ps_in == 3'd5 && m_stk.size() == 0));
      if (!stall) begin
        case (ps_in)
          3'd1: m_pc = 16'(m_pc + 16'd1);
          3'd2: m_pc = 16'(m_pc + ia_in);
          3'd3: m_pc = ra_in;
          3'd4: begin
            m_stk.push_back(16'(m_pc + 16'd1));
            if (m_stk.size() > DEPTH) void'(m_stk.pop_front());
            m_pc = ra_in;
          end
          3'd5: begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else                  m_pc = 16'(m_pc + 16'd1);
          end
          default: ;
        endcase
      end
`ifdef PC_STACK_ERR_EN
      if (set_err)      m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
`else
      if (set_err) m_err = 1'b1;
`endif
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk("model_pc", 32'(pc_out), 32'(m_pc));
      chk("model_cnt", 32'(stk_cnt), 32'(m_stk.size()));
      chk("model_empty", 32'(stk_empty), 32'(m_stk.size() == 0));
      chk("model_full", 32'(stk_full), 32'(m_stk.size() == DEPTH));
`ifdef PC_STACK_ERR_EN
      chk("model_err", 32'(stk_err), 32'(m_err));
`endif
    end
  end

  task automatic step(input logic [2:0] op, input logic [15:0] ia, input logic [15:0] ra, input logic st);
    ps_in = op; ia_in = ia; ra_in = ra; stall = st;
    @(posedge clk);
    #1;
    $display("op=%0d stall=%0b ia=0x%04h ra=0x%04h -> pc=0x%04h cnt=%0d empty=%0b full=%0b",
             op, st, ia, ra, pc_out, stk_cnt, stk_empty, stk_full);
  endtask

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b1;
    armed = 1'b1;
    chk("rst_pc", 32'(pc_out), 32'h0000);
    chk("rst_cnt", 32'(stk_cnt), 32'd0);
    chk("rst_empty", 32'(stk_empty), 32'd1);
    chk("rst_full", 32'(stk_full), 32'd0);

    repeat (3) step(3'd1, 16'h0, 16'h0, 1'b0);
    chk("inc3_pc", 32'(pc_out), 32'h0003);
    step(3'd4, 16'h0, 16'h0040, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_pc", 32'(pc_out), 32'h0000);
    chk("midrst_cnt", 32'(stk_cnt), 32'd0);
    #3 rst_n = 1'b1;

    step(3'd3, 16'h0, 16'h0010, 1'b0);
    step(3'd2, 16'hFFF0, 16'h0, 1'b0);
    chk("bra_neg", 32'(pc_out), 32'h0000);
    step(3'd3, 16'h0, 16'hFFFF, 1'b0);
    step(3'd1, 16'h0, 16'h0, 1'b0);
    chk("inc_wrap", 32'(pc_out), 32'h0000);
    step(3'd2, 16'h7FFF, 16'h0, 1'b0);
    step(3'd2, 16'h0003, 16'h0, 1'b0);
    chk("bra_pos_wrap", 32'(pc_out), 32'h8002);

    step(3'd3, 16'h0, 16'h0020, 1'b0);
    step(3'd4, 16'h0, 16'h0100, 1'b0);
    chk("call_pc", 32'(pc_out), 32'h0100);
    chk("call_cnt", 32'(stk_cnt), 32'd1);
    step(3'd5, 16'h0, 16'h0, 1'b0);
    chk("ret_pc", 32'(pc_out), 32'h0021);
    chk("ret_cnt", 32'(stk_cnt), 32'd0);
    chk("ret_empty", 32'(stk_empty), 32'd1);

    step(3'd3, 16'h0, 16'h0000, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      step(3'd4, 16'h0, 16'(i * 16'h1000), 1'b0);
      if (i == 4) chk("call4_full", 32'(stk_full), 32'd1);
    end
    chk("ovf_full", 32'(stk_full), 32'd1);
    chk("ovf_cnt", 32'(stk_cnt), 32'd4);
    chk("ovf_pc", 32'(pc_out), 32'h5000);
`ifdef PC_STACK_ERR_EN
    chk("ovf_err", 32'(stk_err), 32'd1);
    err_clr = 1'b1;
    step(3'd0, 16'h0, 16'h0, 1'b0);
    err_clr = 1'b0;
    chk("err_clr", 32'(stk_err), 32'd0);
`endif
    for (int i = 4; i >= 1; i--) begin
      step(3'd5, 16'h0, 16'h0, 1'b0);
      chk("nest_ret", 32'(pc_out), 32'(i * 16'h1000 + 16'h0001));
    end
    step(3'd5, 16'h0, 16'h0, 1'b0);
    chk("unf_pc", 32'(pc_out), 32'h1002);
    chk("unf_cnt", 32'(stk_cnt), 32'd0);
`ifdef PC_STACK_ERR_EN
    chk("unf_err", 32'(stk_err), 32'd1);
`endif

    step(3'd3, 16'h0, 16'hBEEF, 1'b1);
    step(3'd3, 16'h0, 16'hBEEF, 1'b1);
    chk("stall_pc", 32'(pc_out), 32'h1002);
    chk("stall_cnt", 32'(stk_cnt), 32'd0);
    step(3'd4, 16'h0, 16'h2222, 1'b1);
    chk("stall_call_cnt", 32'(stk_cnt), 32'd0);
    step(3'd3, 16'h0, 16'hBEEF, 1'b0);
    chk("unstall_pc", 32'(pc_out), 32'hBEEF);

    step(3'd4, 16'h0, 16'h0300, 1'b0);
    step(3'd6, 16'h1234, 16'h5678, 1'b0);
    step(3'd7, 16'h1234, 16'h5678, 1'b0);
    chk("rsv_pc", 32'(pc_out), 32'h0300);
    chk("rsv_cnt", 32'(stk_cnt), 32'd1);
    step(3'd5, 16'h0, 16'h0, 1'b0);
    chk("rsv_ret", 32'(pc_out), 32'hBEF0);

    @(negedge clk);
    armed = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
